// File: rtl/ldm_stm_sequencer.sv
// LDM/STM block-transfer sequencer. Walks a 16-bit register list in
// ascending order, one single-beat memory transfer per register, using
// ARM P/U/W addressing with optional base writeback.
module ldm_stm_sequencer #(
  parameter int ADDR_W = 32,
  parameter int REG_W  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              is_load,
  input  logic              pre_index,
  input  logic              up,
  input  logic              writeback,
  input  logic [REG_W-1:0]  base_reg,
  input  logic [ADDR_W-1:0] base_value,
  input  logic [15:0]       reg_list,
  output logic              busy,
  output logic              done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [ADDR_W-1:0] mem_rdata,
  output logic [REG_W-1:0]  rf_read_num,
  input  logic [ADDR_W-1:0] rf_read_data,
  output logic [REG_W-1:0]  rf_write_reg,
  output logic [ADDR_W-1:0] rf_write_data,
  output logic              rf_regwrite
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_XFER  = 3'd2;
  localparam logic [2:0] S_STEP  = 3'd3;
  localparam logic [2:0] S_WB    = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]        state;
  logic              ld_q, pre_q, up_q, wb_q, base_hit_q;
  logic [REG_W-1:0]  base_reg_q, last_reg;
  logic [ADDR_W-1:0] base_q, addr_q, final_q, data_q;
  logic [15:0]       list_q;   // registers still to transfer

  function automatic logic [4:0] popcount(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) n = n + {4'd0, v[i]};
    return n;
  endfunction

  function automatic logic [REG_W-1:0] lowest(input logic [15:0] v);
    logic [REG_W-1:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) if (v[i]) idx = REG_W'(i);
    return idx;
  endfunction

  logic [ADDR_W-1:0] four_n, start_addr, final_base;
  logic [REG_W-1:0]  cur_reg;

  // Address arithmetic for SETUP, all modulo 2^ADDR_W.
  always_comb begin
    four_n = ADDR_W'({popcount(list_q), 2'b00});
    case ({pre_q, up_q})
      2'b01:   start_addr = base_q;
      2'b11:   start_addr = base_q + ADDR_W'(4);
      2'b00:   start_addr = base_q - four_n + ADDR_W'(4);
      default: start_addr = base_q - four_n;
    endcase
    final_base = up_q ? base_q + four_n : base_q - four_n;
    cur_reg    = lowest(list_q);
  end

  // Sequencer state and command/progress registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= S_IDLE;
      ld_q       <= 1'b0;
      pre_q      <= 1'b0;
      up_q       <= 1'b0;
      wb_q       <= 1'b0;
      base_hit_q <= 1'b0;
      base_reg_q <= '0;
      last_reg   <= '0;
      base_q     <= '0;
      addr_q     <= '0;
      final_q    <= '0;
      data_q     <= '0;
      list_q     <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          ld_q       <= is_load;
          pre_q      <= pre_index;
          up_q       <= up;
          wb_q       <= writeback;
          base_reg_q <= base_reg;
          base_q     <= base_value;
          list_q     <= reg_list;
          base_hit_q <= reg_list[base_reg];
          state      <= S_SETUP;
        end
        S_SETUP: begin
          addr_q  <= start_addr;
          final_q <= final_base;
          state   <= (list_q == '0) ? S_DONE : S_XFER;
        end
        S_XFER: if (mem_ack) begin
          data_q           <= mem_rdata;
          last_reg         <= cur_reg;
          list_q[cur_reg]  <= 1'b0;
          addr_q           <= addr_q + ADDR_W'(4);
          state            <= S_STEP;
        end
        S_STEP: begin
          // A loaded base value takes precedence over writeback.
          if (list_q != '0)                   state <= S_XFER;
          else if (wb_q && !(ld_q && base_hit_q)) state <= S_WB;
          else                                state <= S_DONE;
        end
        S_WB:    state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Output decode; everything idles at zero outside its owning state.
  always_comb begin
    busy          = (state != S_IDLE);
    done          = (state == S_DONE);
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    rf_read_num   = '0;
    rf_regwrite   = 1'b0;
    rf_write_reg  = '0;
    rf_write_data = '0;
    case (state)
      S_XFER: begin
        mem_req  = 1'b1;
        mem_we   = !ld_q;
        mem_addr = addr_q;
        if (!ld_q) begin
          rf_read_num = cur_reg;
          mem_wdata   = rf_read_data;
        end
      end
      S_STEP: if (ld_q) begin
        rf_regwrite   = 1'b1;
        rf_write_reg  = last_reg;
        rf_write_data = data_q;
      end
      S_WB: begin
        rf_regwrite   = 1'b1;
        rf_write_reg  = base_reg_q;
        rf_write_data = final_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Scoreboard bench for ldm_stm_sequencer: directed commands push the
// expected memory beats / register writes / done into a queue, a monitor
// pops and compares whatever the DUT emits.
module tb_ldm_stm_sequencer;
  logic        clock = 1'b0, reset, start, is_load, pre_index, up, writeback;
  logic [3:0]  base_reg;
  logic [31:0] base_value;
  logic [15:0] reg_list;
  logic        busy, done, mem_req, mem_we, mem_ack, rf_regwrite;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, rf_read_data, rf_write_data;
  logic [3:0]  rf_read_num, rf_write_reg;

  int checks = 0, errors = 0;
  int lat = 0;

  typedef struct {int kind; logic [31:0] a; logic [31:0] d;} ev_t; // 0 load,1 store,2 rf,3 done
  ev_t sb[$];
  logic [31:0] ld_data[$];
  logic [31:0] rf[16];

  always #5 clock = ~clock;

  ldm_stm_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .is_load(is_load),
    .pre_index(pre_index), .up(up), .writeback(writeback),
    .base_reg(base_reg), .base_value(base_value), .reg_list(reg_list),
    .busy(busy), .done(done), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .rf_read_num(rf_read_num),
    .rf_read_data(rf_read_data), .rf_write_reg(rf_write_reg),
    .rf_write_data(rf_write_data), .rf_regwrite(rf_regwrite)
  );

  assign rf_read_data = rf[rf_read_num];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input int k, input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    e.kind = k; e.a = a; e.d = d;
    sb.push_back(e);
  endtask

  task automatic got_ev(input int k, input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL unexpected event: got kind %0d a=%h d=%h, expected none", k, a, d);
    end else begin
      e = sb.pop_front();
      if (e.kind != k || e.a !== a || e.d !== d) begin
        errors++;
        $display("FAIL event: got kind %0d a=%h d=%h expected kind %0d a=%h d=%h",
                 k, a, d, e.kind, e.a, e.d);
      end
    end
  endtask

  // Memory responder: ack after 'lat' wait cycles, data from ld_data.
  initial begin
    int wcnt;
    wcnt = 0; mem_ack = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clock); #1;
      if (mem_req && !mem_ack) begin
        if (wcnt >= lat) begin
          mem_ack   = 1'b1;
          mem_rdata = (ld_data.size() != 0) ? ld_data.pop_front() : 32'hBAD0BAD0;
          wcnt      = 0;
        end else wcnt++;
      end else begin
        mem_ack = 1'b0;
        wcnt    = 0;
      end
    end
  end

  // Monitor: observed events go to the scoreboard, pending requests must hold.
  logic        pend = 1'b0, pwe;
  logic [31:0] paddr, pwdata;
  always @(negedge clock) begin
    if (mem_req && mem_ack) got_ev(mem_we ? 1 : 0, mem_addr, mem_we ? mem_wdata : 32'h0);
    if (rf_regwrite) got_ev(2, {28'h0, rf_write_reg}, rf_write_data);
    if (done) got_ev(3, 32'h0, 32'h0);
    if (pend && mem_req) begin
      chk("stable mem_addr", mem_addr, paddr);
      chk("stable mem_wdata", mem_wdata, pwdata);
      chk("stable mem_we", {31'h0, mem_we}, {31'h0, pwe});
    end
    pend   = mem_req && !mem_ack;
    paddr  = mem_addr;
    pwdata = mem_wdata;
    pwe    = mem_we;
  end

  task automatic issue(input bit ld, input bit p, input bit u, input bit w,
                       input logic [3:0] br, input logic [31:0] bv, input logic [15:0] lst);
    @(posedge clock); #1;
    is_load = ld; pre_index = p; up = u; writeback = w;
    base_reg = br; base_value = bv; reg_list = lst; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 300; i++) begin
      if (!busy) break;
      @(posedge clock); #1;
    end
    chk({name, " timeout busy"}, {31'h0, busy}, 32'h0);
    chk({name, " scoreboard left"}, sb.size(), 0);
    sb.delete();
  endtask

  task automatic check_quiet(input string name);
    chk({name, " busy"}, {31'h0, busy}, 32'h0);
    chk({name, " done"}, {31'h0, done}, 32'h0);
    chk({name, " mem_req"}, {31'h0, mem_req}, 32'h0);
    chk({name, " mem_we"}, {31'h0, mem_we}, 32'h0);
    chk({name, " rf_regwrite"}, {31'h0, rf_regwrite}, 32'h0);
    chk({name, " mem_addr"}, mem_addr, 32'h0);
    chk({name, " mem_wdata"}, mem_wdata, 32'h0);
    chk({name, " rf_read_num"}, {28'h0, rf_read_num}, 32'h0);
    chk({name, " rf_write"}, {28'h0, rf_write_reg} | rf_write_data, 32'h0);
  endtask

  initial begin
    bit hit;
    for (int i = 0; i < 16; i++) rf[i] = 32'h0;
    rf[0] = 32'h11; rf[1] = 32'h22; rf[14] = 32'h33; rf[6] = 32'h66; rf[7] = 32'h77;
    reset = 1'b0; start = 1'b0; is_load = 1'b0; pre_index = 1'b0; up = 1'b0;
    writeback = 1'b0; base_reg = '0; base_value = '0; reg_list = '0;
    repeat (3) @(posedge clock);
    #1 check_quiet("reset");
    reset = 1'b1;

    // LDMIA r0=0x100 {r1,r2,r5}!
    lat = 0;
    ld_data = '{32'hA1, 32'hA2, 32'hA5};
    expect_ev(0, 32'h100, 0); expect_ev(2, 1, 32'hA1);
    expect_ev(0, 32'h104, 0); expect_ev(2, 2, 32'hA2);
    expect_ev(0, 32'h108, 0); expect_ev(2, 5, 32'hA5);
    expect_ev(2, 0, 32'h10C); expect_ev(3, 0, 0);
    issue(1, 0, 1, 1, 4'd0, 32'h100, 16'h0026);
    wait_idle("ldmia");

    // STMDB r13=0x200 {r0,r1,r14}!
    expect_ev(1, 32'h1F4, 32'h11); expect_ev(1, 32'h1F8, 32'h22);
    expect_ev(1, 32'h1FC, 32'h33); expect_ev(2, 13, 32'h1F4); expect_ev(3, 0, 0);
    issue(0, 1, 0, 1, 4'd13, 32'h200, 16'h4003);
    wait_idle("stmdb");

    // Empty list with writeback: done in the third cycle counting the start cycle.
    expect_ev(3, 0, 0);
    issue(1, 0, 1, 1, 4'd2, 32'h80, 16'h0000);
    chk("empty setup done", {31'h0, done}, 32'h0);
    chk("empty setup busy", {31'h0, busy}, 32'h1);
    @(posedge clock); #1;
    chk("empty done pulse", {31'h0, done}, 32'h1);
    wait_idle("empty");

    // LDMIB r3=0x40 {r3,r4}!: loaded base wins, no writeback.
    ld_data = '{32'hDEAD, 32'hBEEF};
    expect_ev(0, 32'h44, 0); expect_ev(2, 3, 32'hDEAD);
    expect_ev(0, 32'h48, 0); expect_ev(2, 4, 32'hBEEF); expect_ev(3, 0, 0);
    issue(1, 1, 1, 1, 4'd3, 32'h40, 16'h0018);
    wait_idle("ldmib");

    // STMIA r5=0x300 {r1,r6,r7}, slow acks, stray start while busy.
    lat = 3;
    expect_ev(1, 32'h300, 32'h22); expect_ev(1, 32'h304, 32'h66);
    expect_ev(1, 32'h308, 32'h77); expect_ev(3, 0, 0);
    issue(0, 0, 1, 0, 4'd5, 32'h300, 16'h00C2);
    repeat (4) @(posedge clock);
    #1 is_load = 1'b1; reg_list = 16'hFFFF; writeback = 1'b1; start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    wait_idle("stmia slow");
    repeat (3) @(posedge clock);
    #1 chk("second start ignored", {31'h0, busy}, 32'h0);

    // Reset in XFER of the second beat of LDMIA r0=0x600 {r1,r2,r3}.
    ld_data = '{32'h71, 32'h72, 32'h73};
    expect_ev(0, 32'h600, 0); expect_ev(2, 1, 32'h71);
    issue(1, 0, 1, 1, 4'd0, 32'h600, 16'h000E);
    hit = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (mem_req && mem_addr == 32'h604) begin hit = 1'b1; break; end
      @(posedge clock); #1;
    end
    chk("reached beat2", {31'h0, hit}, 32'h1);
    reset = 1'b0;
    @(posedge clock); #1;
    check_quiet("abort");
    @(posedge clock); #1;
    check_quiet("abort hold");
    reset = 1'b1;
    chk("abort scoreboard", sb.size(), 0);
    sb.delete();
    ld_data.delete();

    // LDMDA r1=0x500 {r0,r2}! after the abort.
    lat = 1;
    ld_data = '{32'h1000, 32'h2000};
    expect_ev(0, 32'h4FC, 0); expect_ev(2, 0, 32'h1000);
    expect_ev(0, 32'h500, 0); expect_ev(2, 2, 32'h2000);
    expect_ev(2, 1, 32'h4F8); expect_ev(3, 0, 0);
    issue(1, 0, 0, 1, 4'd1, 32'h500, 16'h0005);
    wait_idle("ldmda");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
